// File: rtl/operand_issue_if.sv
// Bundle of signals between the decode/regfile/writeback/execute environment
// and the operand_issue stage. The stage uses the slave view; whatever
// surrounds it (decode, regfile, execute, or a bench) uses the master view.
interface operand_issue_if #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 32
);
  // Decoded instruction from decode
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              in_rd_we;

  // Regfile read port pair (combinational read, pre-write data)
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;

  // Writeback (also drives regfile write port 0)
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;

  // Redirect kill of the instruction held in the output register
  logic              flush;

  // Issued instruction toward execute
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_op1;
  logic [XLEN-1:0]   out_op2;
  logic [4:0]        out_rd;
  logic              out_rd_we;

  modport master (
    output in_valid, in_pc, in_ctrl, in_rs1, in_rs2, in_rd, in_rd_we,
    output rd1, rd2, wb_valid, wb_addr, wb_data, flush, out_ready,
    input  in_ready, ra1, ra2,
    input  out_valid, out_pc, out_ctrl, out_op1, out_op2, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, in_pc, in_ctrl, in_rs1, in_rs2, in_rd, in_rd_we,
    input  rd1, rd2, wb_valid, wb_addr, wb_data, flush, out_ready,
    output in_ready, ra1, ra2,
    output out_valid, out_pc, out_ctrl, out_op1, out_op2, out_rd, out_rd_we
  );
endinterface

// File: rtl/operand_issue.sv
// Decode-to-execute issue stage. Drives the regfile read addresses, bypasses
// same-cycle writeback data into the operands, stalls on RAW hazards against
// a 32-entry pending-writer scoreboard, and registers the issued instruction
// toward execute behind a valid/ready handshake.
module operand_issue #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  operand_issue_if.slave  io
);

  // Output register and scoreboard state
  logic              out_valid_q;
  logic [63:0]       out_pc_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [XLEN-1:0]   out_op1_q;
  logic [XLEN-1:0]   out_op2_q;
  logic [4:0]        out_rd_q;
  logic              out_rd_we_q;
  logic [31:0]       pending;

  // Combinational decisions
  logic              wb_hit1;
  logic              wb_hit2;
  logic              haz;
  logic              in_ready;
  logic              issue;
  logic [XLEN-1:0]   op1;
  logic [XLEN-1:0]   op2;
  logic [31:0]       set_vec;
  logic [31:0]       flush_clr;
  logic [31:0]       wb_clr;
  logic [31:0]       pending_nxt;

  // Regfile is read straight from the decoded sources
  assign io.ra1 = io.in_rs1;
  assign io.ra2 = io.in_rs2;

  // A writeback to a source register resolves that operand this cycle;
  // x0 never matches because it is never pending and always reads zero.
  assign wb_hit1 = io.wb_valid && (io.wb_addr == io.in_rs1) && (io.wb_addr != 5'd0);
  assign wb_hit2 = io.wb_valid && (io.wb_addr == io.in_rs2) && (io.wb_addr != 5'd0);

  assign haz = (pending[io.in_rs1] && !wb_hit1 && (io.in_rs1 != 5'd0))
            || (pending[io.in_rs2] && !wb_hit2 && (io.in_rs2 != 5'd0));

  // Flush takes the cycle: the redirect makes anything in decode stale too
  assign in_ready = !io.flush && !haz && (!out_valid_q || io.out_ready);
  assign issue    = io.in_valid && in_ready;
  assign io.in_ready = in_ready;

  // Operand select: x0, then same-cycle writeback, then regfile read data
  always_comb begin
    // NOTE: every output gets a default before any branch so no path infers a latch.
    op1 = io.rd1;
    op2 = io.rd2;
    if (io.in_rs1 == 5'd0) op1 = '0;
    else if (wb_hit1)      op1 = io.wb_data;
    if (io.in_rs2 == 5'd0) op2 = '0;
    else if (wb_hit2)      op2 = io.wb_data;
  end

  // Scoreboard next state: a new writer is younger than any same-cycle clear,
  // so its set wins; bit 0 is forced low.
  always_comb begin
    set_vec   = '0;
    flush_clr = '0;
    wb_clr    = '0;
    if (issue && io.in_rd_we)                      set_vec   = 32'd1 << io.in_rd;
    if (io.flush && out_valid_q && out_rd_we_q)    flush_clr = 32'd1 << out_rd_q;
    if (io.wb_valid)                               wb_clr    = 32'd1 << io.wb_addr;
    pending_nxt = (set_vec | (pending & ~flush_clr & ~wb_clr)) & ~32'd1;
  end

  // Output register: load on issue, drain on accept or flush, else hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
    end else if (issue) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= 1'b1;
      out_pc_q    <= io.in_pc;
      out_ctrl_q  <= io.in_ctrl;
      out_op1_q   <= op1;
      out_op2_q   <= op2;
      out_rd_q    <= io.in_rd;
      out_rd_we_q <= io.in_rd_we && (io.in_rd != 5'd0);
    end else if (io.out_ready || io.flush) begin
      out_valid_q <= 1'b0;
    end
  end

  // Pending-writer scoreboard
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the scoreboard is reset, unlike a data array: a stale bit would stall its register forever.
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign io.out_valid = out_valid_q;
  assign io.out_pc    = out_pc_q;
  assign io.out_ctrl  = out_ctrl_q;
  assign io.out_op1   = out_op1_q;
  assign io.out_op2   = out_op2_q;
  assign io.out_rd    = out_rd_q;
  assign io.out_rd_we = out_rd_we_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue. Inputs change 1ns after a rising edge;
// combinational outputs are sampled 1ns later and registered outputs are
// sampled 1ns after the following rising edge.
module tb_operand_issue;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 32;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  operand_issue_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  operand_issue #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_ctrl   = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.in_rd_we  = 1'b0;
    bus.rd1       = '0;
    bus.rd2       = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive_instr(input logic [63:0] pc, input logic [31:0] ctrl,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic rd_we);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_ctrl  = ctrl;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_rd_we = rd_we;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    tests_run++;
    if (dut.pending !== 32'h0) begin
      tests_failed++; $display("FAIL reset_pending: got %h expected 00000000", dut.pending);
    end
    tests_run++;
    if (bus.out_op1 !== 64'h0 || bus.out_pc !== 64'h0 || bus.out_rd_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: got op1=%h pc=%h rd_we=%b expected zeros", bus.out_op1, bus.out_pc, bus.out_rd_we);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // RAW stall on x5 until its writeback, which is then bypassed into op1
  task automatic test_raw_stall();
    drive_instr(64'h100, 32'h1, 5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd5 || bus.out_rd_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL raw_producer: got valid=%b rd=%0d we=%b expected 1 5 1", bus.out_valid, bus.out_rd, bus.out_rd_we);
    end
    tests_run++;
    if (dut.pending !== 32'h0000_0020) begin
      tests_failed++; $display("FAIL raw_pending_set: got %h expected 00000020", dut.pending);
    end
    drive_instr(64'h104, 32'h2, 5'd5, 5'd0, 5'd6, 1'b0);
    bus.rd1 = 64'h55;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
        tests_failed++; $display("FAIL raw_stall_cycle%0d: got in_ready=%b expected 0", c, bus.in_ready);
      end
      tick();
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL raw_bubble: got out_valid=%b expected 0", bus.out_valid);
    end
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd5;
    bus.wb_data  = 64'hAB;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.ra1 !== 5'd5) begin
      tests_failed++; $display("FAIL raw_release: got in_ready=%b ra1=%0d expected 1 5", bus.in_ready, bus.ra1);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_op1 !== 64'hAB || bus.out_pc !== 64'h104) begin
      tests_failed++;
      $display("FAIL raw_bypass: got valid=%b op1=%h pc=%h expected 1 ab 104", bus.out_valid, bus.out_op1, bus.out_pc);
    end
    tests_run++;
    if (dut.pending !== 32'h0) begin
      tests_failed++; $display("FAIL raw_pending_clear: got %h expected 00000000", dut.pending);
    end
    drive_idle();
  endtask

  // x0 sources read zero; x0 destination never becomes pending
  task automatic test_x0();
    drive_instr(64'h180, 32'h3, 5'd0, 5'd0, 5'd0, 1'b1);
    bus.rd1 = 64'hFFFF;
    bus.rd2 = 64'hFFFF;
    tick();
    tests_run++;
    if (bus.out_op1 !== 64'h0 || bus.out_op2 !== 64'h0) begin
      tests_failed++; $display("FAIL x0_operands: got op1=%h op2=%h expected 0 0", bus.out_op1, bus.out_op2);
    end
    tests_run++;
    if (bus.out_rd_we !== 1'b0 || dut.pending !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_dest: got rd_we=%b pending=%h expected 0 00000000", bus.out_rd_we, dut.pending);
    end
    drive_idle();
  endtask

  // Output held stable for three cycles of backpressure
  task automatic test_backpressure();
    drive_instr(64'h200, 32'hDEAD, 5'd1, 5'd2, 5'd9, 1'b1);
    bus.rd1 = 64'h11;
    bus.rd2 = 64'h22;
    tick();
    bus.out_ready = 1'b0;
    drive_instr(64'h300, 32'hBEEF, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.rd1 = 64'h77;
    bus.rd2 = 64'h88;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
        tests_failed++; $display("FAIL bp_in_ready_cycle%0d: got %b expected 0", c, bus.in_ready);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h200 || bus.out_ctrl !== 32'hDEAD ||
          bus.out_op1 !== 64'h11 || bus.out_op2 !== 64'h22 || bus.out_rd !== 5'd9) begin
        tests_failed++;
        $display("FAIL bp_hold_cycle%0d: got valid=%b pc=%h ctrl=%h op1=%h op2=%h rd=%0d expected 1 200 dead 11 22 9",
                 c, bus.out_valid, bus.out_pc, bus.out_ctrl, bus.out_op1, bus.out_op2, bus.out_rd);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_release: got in_ready=%b expected 1", bus.in_ready);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h300 || bus.out_ctrl !== 32'hBEEF) begin
      tests_failed++;
      $display("FAIL bp_next: got valid=%b pc=%h ctrl=%h expected 1 300 beef", bus.out_valid, bus.out_pc, bus.out_ctrl);
    end
    drive_idle();
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd9;
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || dut.pending !== 32'h0) begin
      tests_failed++;
      $display("FAIL bp_drain: got valid=%b pending=%h expected 0 00000000", bus.out_valid, dut.pending);
    end
    drive_idle();
  endtask

  // Same-cycle set vs writeback clear, then flush releases the bit
  task automatic test_set_flush();
    drive_instr(64'h400, 32'h7, 5'd0, 5'd0, 5'd7, 1'b1);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd7;
    bus.wb_data  = 64'h1234;
    tick();
    tests_run++;
    if (dut.pending !== 32'h0000_0080) begin
      tests_failed++; $display("FAIL set_beats_wb: got pending=%h expected 00000080", dut.pending);
    end
    drive_instr(64'h404, 32'h8, 5'd0, 5'd0, 5'd8, 1'b1);
    bus.wb_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || dut.pending !== 32'h0) begin
      tests_failed++;
      $display("FAIL flush_release: got valid=%b pending=%h expected 0 00000000", bus.out_valid, dut.pending);
    end
    drive_idle();
  endtask

  // Writeback bypass beats stale regfile data on a non-pending source
  task automatic test_wb_bypass();
    drive_instr(64'h500, 32'h9, 5'd4, 5'd3, 5'd0, 1'b0);
    bus.rd1      = 64'h44;
    bus.rd2      = 64'h99;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd3;
    bus.wb_data  = 64'h10;
    tick();
    tests_run++;
    if (bus.out_op2 !== 64'h10 || bus.out_op1 !== 64'h44) begin
      tests_failed++;
      $display("FAIL wb_bypass: got op1=%h op2=%h expected 44 10", bus.out_op1, bus.out_op2);
    end
    drive_idle();
  endtask

  // Asynchronous reset with a valid output and a pending bit
  task automatic test_async_reset();
    drive_instr(64'h600, 32'hA, 5'd0, 5'd0, 5'd12, 1'b1);
    tick();
    drive_idle();
    bus.out_ready = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || dut.pending !== 32'h0000_1000) begin
      tests_failed++;
      $display("FAIL areset_pre: got valid=%b pending=%h expected 1 00001000", bus.out_valid, dut.pending);
    end
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || dut.pending !== 32'h0 || bus.out_pc !== 64'h0) begin
      tests_failed++;
      $display("FAIL areset_now: got valid=%b pending=%h pc=%h expected 0 00000000 0",
               bus.out_valid, dut.pending, bus.out_pc);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    drive_idle();
    test_reset();
    test_raw_stall();
    test_x0();
    test_backpressure();
    test_set_flush();
    test_wb_bypass();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
